// File: rtl/ecc_hdr_pkg.sv
// Shared definitions for the MIPI packet-header ECC pipeline: field offsets,
// parity-bit masks and the ECC generator.
package ecc_hdr_pkg;

    localparam int unsigned HDR_W      = 32;
    localparam int unsigned DATA_W     = 24;
    localparam int unsigned ECC_W      = 6;
    localparam int unsigned DI_LSB     = 0;
    localparam int unsigned WC_LSB_LSB = 8;
    localparam int unsigned WC_MSB_LSB = 16;
    localparam int unsigned ECC_LSB    = 24;

    // Bit i of Pn_MASK set means data bit i contributes to parity bit n.
    localparam logic [DATA_W-1:0] P0_MASK = 24'hF12CB7;
    localparam logic [DATA_W-1:0] P1_MASK = 24'hF2555B;
    localparam logic [DATA_W-1:0] P2_MASK = 24'h749A6D;
    localparam logic [DATA_W-1:0] P3_MASK = 24'hB8E38E;
    localparam logic [DATA_W-1:0] P4_MASK = 24'hDF03F0;
    localparam logic [DATA_W-1:0] P5_MASK = 24'hEFFC00;

    typedef logic [DATA_W-1:0] hdr_data_t;
    typedef logic [ECC_W-1:0]  ecc_t;

    typedef enum logic [1:0] {
        SYN_CLEAN,
        SYN_DATA,
        SYN_ECC,
        SYN_FATAL
    } syn_kind_t;

    function automatic ecc_t ecc_calc(input hdr_data_t d);
        ecc_t p;
        p[0] = ^(d & P0_MASK);
        p[1] = ^(d & P1_MASK);
        p[2] = ^(d & P2_MASK);
        p[3] = ^(d & P3_MASK);
        p[4] = ^(d & P4_MASK);
        p[5] = ^(d & P5_MASK);
        return p;
    endfunction

    // Syndrome produced by a single flip of data bit i.
    function automatic ecc_t ecc_col(input logic [4:0] i);
        return {P5_MASK[i], P4_MASK[i], P3_MASK[i], P2_MASK[i], P1_MASK[i], P0_MASK[i]};
    endfunction

endpackage

// File: rtl/ecc_hdr_lane_fix.sv
// One header lane: classify the syndrome, correct a single-bit error and
// rebuild the ECC byte.
module ecc_hdr_lane_fix
    import ecc_hdr_pkg::*;
(
    input  logic [DATA_W-1:0] i_data,
    input  logic [ECC_W-1:0]  i_syn,
    input  logic [7:0]        i_ecc_rx,
    output logic [HDR_W-1:0]  o_hdr,
    output logic              o_corr,
    output logic              o_fatal
);

    syn_kind_t         w_kind;
    logic [DATA_W-1:0] w_match;
    logic [DATA_W-1:0] w_data;

    always_comb begin
        w_match = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            w_match[i] = (i_syn == ecc_col(5'(i)));
        end
    end

    // Data columns all carry weight >= 3, so the data match is tested before one-hot.
    always_comb begin
        if (i_syn == '0) begin
            w_kind = SYN_CLEAN;
        end else if (|w_match) begin
            w_kind = SYN_DATA;
        end else if ($onehot(i_syn)) begin
            w_kind = SYN_ECC;
        end else begin
            w_kind = SYN_FATAL;
        end
    end

    always_comb begin
        w_data  = i_data;
        o_corr  = 1'b0;
        o_fatal = 1'b0;
        unique case (w_kind)
            SYN_DATA: begin
                w_data = i_data ^ w_match;
                o_corr = 1'b1;
            end
            SYN_ECC:   o_corr  = 1'b1;
            SYN_FATAL: o_fatal = 1'b1;
            default: ;
        endcase
        if (w_kind == SYN_FATAL) begin
            o_hdr = {i_ecc_rx & 8'h3F, w_data};
        end else begin
            o_hdr = {2'b00, ecc_calc(w_data), w_data};
        end
    end

endmodule

// File: rtl/ecc_hdr_pipe.sv
// Two-stage MIPI packet-header ECC generate/check pipeline, NUM_HDR lanes per beat.
// Define ECC_HDR_ERR_CNT_EN to add the saturating corrected/fatal event counters.
module ecc_hdr_pipe
    import ecc_hdr_pkg::*;
#(
    parameter int unsigned NUM_HDR  = 1,
    parameter bit          CHECK_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef ECC_HDR_ERR_CNT_EN
    input  logic                  cnt_clr,
    output logic [15:0]           corr_cnt,
    output logic [15:0]           fatal_cnt,
`endif
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [32*NUM_HDR-1:0] s_hdr,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [32*NUM_HDR-1:0] m_hdr,
    output logic [NUM_HDR-1:0]    m_err_corr,
    output logic [NUM_HDR-1:0]    m_err_fatal
);

    logic                              w_en;
    logic                              r1_valid;
    logic [NUM_HDR-1:0][DATA_W-1:0]    r1_data;
    logic [NUM_HDR-1:0][7:0]           r1_ecc;
    logic [NUM_HDR-1:0][ECC_W-1:0]     r1_syn;
    logic [NUM_HDR-1:0][HDR_W-1:0]     w_hdr;
    logic [NUM_HDR-1:0]                w_corr;
    logic [NUM_HDR-1:0]                w_fatal;
    logic                              r_m_valid;
    logic [NUM_HDR-1:0][HDR_W-1:0]     r_m_hdr;
    logic [NUM_HDR-1:0]                r_m_corr;
    logic [NUM_HDR-1:0]                r_m_fatal;

    assign w_en    = !r_m_valid || m_ready;
    assign s_ready = w_en;

    // In generate mode r1_syn carries the computed ECC rather than a syndrome.
    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid <= 1'b0;
        end else if (w_en) begin
            r1_valid <= s_valid;
            if (s_valid) begin
                for (int unsigned k = 0; k < NUM_HDR; k++) begin
                    r1_data[k] <= s_hdr[HDR_W*k +: DATA_W];
                    r1_ecc[k]  <= s_hdr[HDR_W*k + ECC_LSB +: 8];
                    r1_syn[k]  <= CHECK_EN ?
                        (s_hdr[HDR_W*k + ECC_LSB +: ECC_W] ^ ecc_calc(s_hdr[HDR_W*k +: DATA_W])) :
                        ecc_calc(s_hdr[HDR_W*k +: DATA_W]);
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_HDR; k++) begin : g_lane
        if (CHECK_EN) begin : g_chk
            ecc_hdr_lane_fix u_fix (
                .i_data   (r1_data[k]),
                .i_syn    (r1_syn[k]),
                .i_ecc_rx (r1_ecc[k]),
                .o_hdr    (w_hdr[k]),
                .o_corr   (w_corr[k]),
                .o_fatal  (w_fatal[k])
            );
        end else begin : g_gen
            assign w_hdr[k]   = {2'b00, r1_syn[k], r1_data[k]};
            assign w_corr[k]  = 1'b0;
            assign w_fatal[k] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_m_hdr   <= '0;
            r_m_corr  <= '0;
            r_m_fatal <= '0;
        end else if (w_en) begin
            r_m_valid <= r1_valid;
            if (r1_valid) begin
                r_m_hdr   <= w_hdr;
                r_m_corr  <= w_corr;
                r_m_fatal <= w_fatal;
            end
        end
    end

    assign m_valid     = r_m_valid;
    assign m_hdr       = r_m_hdr;
    assign m_err_corr  = r_m_corr;
    assign m_err_fatal = r_m_fatal;

`ifdef ECC_HDR_ERR_CNT_EN
    logic [15:0] r_corr_cnt;
    logic [15:0] r_fatal_cnt;
    logic [16:0] w_corr_sum;
    logic [16:0] w_fatal_sum;

    always_comb begin
        w_corr_sum  = {1'b0, r_corr_cnt}  + 17'($countones(r_m_corr));
        w_fatal_sum = {1'b0, r_fatal_cnt} + 17'($countones(r_m_fatal));
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_corr_cnt  <= '0;
            r_fatal_cnt <= '0;
        end else if (r_m_valid && m_ready) begin
            r_corr_cnt  <= w_corr_sum[16]  ? '1 : w_corr_sum[15:0];
            r_fatal_cnt <= w_fatal_sum[16] ? '1 : w_fatal_sum[15:0];
        end
    end

    assign corr_cnt  = r_corr_cnt;
    assign fatal_cnt = r_fatal_cnt;
`endif

endmodule

// File: tb/tb_ecc_hdr_pipe.sv
// Directed self-checking bench: one generate-mode lane and a four-lane check-mode pipe.
module tb_ecc_hdr_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         g_s_valid = 1'b0, g_s_ready, g_m_valid, g_m_ready = 1'b1;
    logic [31:0]  g_s_hdr = '0, g_m_hdr;
    logic [0:0]   g_corr, g_fatal;

    logic         c_s_valid = 1'b0, c_s_ready, c_m_valid, c_m_ready = 1'b1;
    logic [127:0] c_s_hdr = '0, c_m_hdr;
    logic [3:0]   c_corr, c_fatal;
`ifdef ECC_HDR_ERR_CNT_EN
    logic         g_cnt_clr = 1'b0, cnt_clr = 1'b0;
    logic [15:0]  g_corr_cnt, g_fatal_cnt, corr_cnt, fatal_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Lanes 3..0: d23 flipped, ECC-byte error, uncorrectable (syn 0x0C), d0 flipped.
    localparam logic [127:0] ERR_IN    = {32'h3B000000, 32'h10000000, 32'h00000003, 32'h07000000};
    localparam logic [127:0] ERR_OUT   = {32'h3B800000, 32'h00000000, 32'h00000003, 32'h07000001};
    localparam logic [127:0] CLEAN_IN  = {32'h80000000, 32'h00000000, 32'h3B800000, 32'hC7000001};
    localparam logic [127:0] CLEAN_OUT = {32'h00000000, 32'h00000000, 32'h3B800000, 32'h07000001};

    ecc_hdr_pipe #(.NUM_HDR(1), .CHECK_EN(1'b0)) u_gen (
        .clk         (clk),
        .rst         (rst),
`ifdef ECC_HDR_ERR_CNT_EN
        .cnt_clr     (g_cnt_clr),
        .corr_cnt    (g_corr_cnt),
        .fatal_cnt   (g_fatal_cnt),
`endif
        .s_valid     (g_s_valid),
        .s_ready     (g_s_ready),
        .s_hdr       (g_s_hdr),
        .m_valid     (g_m_valid),
        .m_ready     (g_m_ready),
        .m_hdr       (g_m_hdr),
        .m_err_corr  (g_corr),
        .m_err_fatal (g_fatal)
    );

    ecc_hdr_pipe #(.NUM_HDR(4), .CHECK_EN(1'b1)) u_chk (
        .clk         (clk),
        .rst         (rst),
`ifdef ECC_HDR_ERR_CNT_EN
        .cnt_clr     (cnt_clr),
        .corr_cnt    (corr_cnt),
        .fatal_cnt   (fatal_cnt),
`endif
        .s_valid     (c_s_valid),
        .s_ready     (c_s_ready),
        .s_hdr       (c_s_hdr),
        .m_valid     (c_m_valid),
        .m_ready     (c_m_ready),
        .m_hdr       (c_m_hdr),
        .m_err_corr  (c_corr),
        .m_err_fatal (c_fatal)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one beat into the check pipe; returns with its result on the outputs.
    task automatic c_beat(input logic [127:0] hdr);
        c_s_hdr   = hdr;
        c_s_valid = 1'b1;
        tick();
        c_s_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        g_s_valid = 1'b1; g_s_hdr = 32'h12345678;
        c_s_valid = 1'b1; c_s_hdr = ERR_IN;
        repeat (3) tick();
        checks++;
        if (g_m_valid !== 1'b0 || c_m_valid !== 1'b0)
            $display("FAIL reset_valid got g=%b c=%b exp 0", g_m_valid, c_m_valid);
        else checks += 0;
        if (g_m_valid !== 1'b0 || c_m_valid !== 1'b0) errors++;
        checks++;
        if (g_m_hdr !== 32'h0 || c_m_hdr !== 128'h0) begin
            $display("FAIL reset_hdr got g=%h c=%h exp 0", g_m_hdr, c_m_hdr); errors++;
        end
        checks++;
        if (c_corr !== 4'h0 || c_fatal !== 4'h0 || g_corr !== 1'b0 || g_fatal !== 1'b0) begin
            $display("FAIL reset_flags got corr=%h fatal=%h exp 0", c_corr, c_fatal); errors++;
        end
`ifdef ECC_HDR_ERR_CNT_EN
        checks++;
        if (corr_cnt !== 16'h0 || fatal_cnt !== 16'h0) begin
            $display("FAIL reset_cnt got %h/%h exp 0", corr_cnt, fatal_cnt); errors++;
        end
`endif
        rst = 1'b0; g_s_valid = 1'b0; c_s_valid = 1'b0;
        tick();
        checks++;
        if (g_s_ready !== 1'b1 || c_s_ready !== 1'b1) begin
            $display("FAIL reset_ready got g=%b c=%b exp 1", g_s_ready, c_s_ready); errors++;
        end
    endtask

    task automatic test_generate();
        logic [23:0] gd [3];
        logic [7:0]  ge [3];
        gd = '{24'h000001, 24'h800000, 24'h000000};
        ge = '{8'h07, 8'h3B, 8'h00};
        g_m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            g_s_hdr   = {8'hA5, gd[i]};
            g_s_valid = 1'b1;
            tick();
            g_s_valid = 1'b0;
            checks++;
            if (g_m_valid !== 1'b0) begin
                $display("FAIL gen_latency%0d got m_valid=%b exp 0", i, g_m_valid); errors++;
            end
            tick();
            checks++;
            if (g_m_valid !== 1'b1 || g_m_hdr !== {ge[i], gd[i]} || g_corr !== 1'b0 || g_fatal !== 1'b0) begin
                $display("FAIL gen%0d got v=%b hdr=%h c=%b f=%b exp v=1 hdr=%h c=0 f=0",
                         i, g_m_valid, g_m_hdr, g_corr, g_fatal, {ge[i], gd[i]});
                errors++;
            end
            tick();
        end
    endtask

    task automatic test_check();
        c_m_ready = 1'b0;
        c_beat(ERR_IN);
        checks++;
        if (c_m_valid !== 1'b1 || c_m_hdr !== ERR_OUT) begin
            $display("FAIL chk_err_hdr got v=%b hdr=%h exp v=1 hdr=%h", c_m_valid, c_m_hdr, ERR_OUT); errors++;
        end
        checks++;
        if (c_corr !== 4'b1101 || c_fatal !== 4'b0010) begin
            $display("FAIL chk_err_flags got corr=%b fatal=%b exp 1101/0010", c_corr, c_fatal); errors++;
        end
        c_s_hdr = CLEAN_IN; c_s_valid = 1'b1;
        repeat (3) tick();
        checks++;
        if (c_s_ready !== 1'b0 || c_m_hdr !== ERR_OUT || c_corr !== 4'b1101 || c_fatal !== 4'b0010) begin
            $display("FAIL chk_hold got rdy=%b hdr=%h corr=%b fatal=%b exp rdy=0 hdr=%h",
                     c_s_ready, c_m_hdr, c_corr, c_fatal, ERR_OUT);
            errors++;
        end
        c_s_valid = 1'b0; c_m_ready = 1'b1;
        tick();
        checks++;
        if (c_m_valid !== 1'b0) begin
            $display("FAIL chk_drain got m_valid=%b exp 0", c_m_valid); errors++;
        end
        c_beat(CLEAN_IN);
        checks++;
        if (c_m_valid !== 1'b1 || c_m_hdr !== CLEAN_OUT || c_corr !== 4'h0 || c_fatal !== 4'h0) begin
            $display("FAIL chk_clean got v=%b hdr=%h corr=%b fatal=%b exp hdr=%h no flags",
                     c_m_valid, c_m_hdr, c_corr, c_fatal, CLEAN_OUT);
            errors++;
        end
        tick();
    endtask

    task automatic test_back_to_back();
        c_m_ready = 1'b1;
        c_s_hdr = ERR_IN; c_s_valid = 1'b1;
        tick();
        c_s_hdr = CLEAN_IN;
        tick();
        c_s_valid = 1'b0;
        checks++;
        if (c_m_valid !== 1'b1 || c_m_hdr !== ERR_OUT || c_corr !== 4'b1101) begin
            $display("FAIL b2b_first got v=%b hdr=%h corr=%b exp hdr=%h", c_m_valid, c_m_hdr, c_corr, ERR_OUT); errors++;
        end
        tick();
        checks++;
        if (c_m_valid !== 1'b1 || c_m_hdr !== CLEAN_OUT || c_corr !== 4'h0 || c_fatal !== 4'h0) begin
            $display("FAIL b2b_second got v=%b hdr=%h corr=%b exp hdr=%h", c_m_valid, c_m_hdr, c_corr, CLEAN_OUT); errors++;
        end
        tick();
        checks++;
        if (c_m_valid !== 1'b0) begin
            $display("FAIL b2b_end got m_valid=%b exp 0", c_m_valid); errors++;
        end
    endtask

    task automatic test_stall();
        int  sent;
        int  rcv;
        bit  stalled;
        sent = 0; rcv = 0; stalled = 1'b0;
        for (int cyc = 0; cyc < 60 && rcv < 12; cyc++) begin
            g_m_ready = !(cyc >= 3 && cyc < 8);
            g_s_valid = (sent < 12);
            g_s_hdr   = {8'h00, 8'h5A, 16'(sent + 1)};
            #2;
            if (g_m_valid && g_m_ready) begin
                checks++;
                if (g_m_hdr[23:0] !== {8'h5A, 16'(rcv + 1)}) begin
                    $display("FAIL stall_order%0d got %h exp %h", rcv, g_m_hdr[23:0], {8'h5A, 16'(rcv + 1)});
                    errors++;
                end
                rcv++;
            end
            if (g_s_valid && g_s_ready) sent++;
            if (g_s_valid && !g_s_ready) stalled = 1'b1;
            tick();
        end
        g_s_valid = 1'b0; g_m_ready = 1'b1;
        checks++;
        if (rcv != 12 || sent != 12) begin
            $display("FAIL stall_count got sent=%0d rcv=%0d exp 12/12", sent, rcv); errors++;
        end
        checks++;
        if (!stalled) begin
            $display("FAIL stall_ready got s_ready never low exp low during stall"); errors++;
        end
        tick();
        checks++;
        if (g_m_valid !== 1'b0) begin
            $display("FAIL stall_dup got m_valid=%b exp 0", g_m_valid); errors++;
        end
    endtask

    task automatic test_reset_midstream();
        c_m_ready = 1'b1;
        c_s_hdr = ERR_IN; c_s_valid = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; c_s_valid = 1'b0;
        checks++;
        if (c_m_valid !== 1'b0 || c_s_ready !== 1'b1) begin
            $display("FAIL midrst got v=%b rdy=%b exp v=0 rdy=1", c_m_valid, c_s_ready); errors++;
        end
        repeat (2) tick();
        checks++;
        if (c_m_valid !== 1'b0) begin
            $display("FAIL midrst_discard got m_valid=%b exp 0", c_m_valid); errors++;
        end
    endtask

`ifdef ECC_HDR_ERR_CNT_EN
    task automatic test_counters();
        c_m_ready = 1'b1; c_s_valid = 1'b0;
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        checks++;
        if (corr_cnt !== 16'd0 || fatal_cnt !== 16'd0) begin
            $display("FAIL cnt_clr got %0d/%0d exp 0/0", corr_cnt, fatal_cnt); errors++;
        end
        c_beat(ERR_IN);
        tick();
        checks++;
        if (corr_cnt !== 16'd3 || fatal_cnt !== 16'd1) begin
            $display("FAIL cnt_beat got %0d/%0d exp 3/1", corr_cnt, fatal_cnt); errors++;
        end
        c_m_ready = 1'b0;
        c_beat(ERR_IN);
        tick();
        cnt_clr = 1'b1; c_m_ready = 1'b1;
        tick();
        cnt_clr = 1'b0;
        checks++;
        if (corr_cnt !== 16'd0 || fatal_cnt !== 16'd0) begin
            $display("FAIL cnt_clr_wins got %0d/%0d exp 0/0", corr_cnt, fatal_cnt); errors++;
        end
        c_s_hdr = ERR_IN; c_s_valid = 1'b1;
        for (int i = 0; i < 21844; i++) tick();
        c_s_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if (corr_cnt !== 16'd65532 || fatal_cnt !== 16'd21844) begin
            $display("FAIL cnt_stream got %0d/%0d exp 65532/21844", corr_cnt, fatal_cnt); errors++;
        end
        c_beat({32'h0, 32'h0, 32'h10000000, 32'h07000000});
        tick();
        checks++;
        if (corr_cnt !== 16'hFFFE) begin
            $display("FAIL cnt_fffe got %h exp fffe", corr_cnt); errors++;
        end
        c_beat(ERR_IN);
        tick();
        checks++;
        if (corr_cnt !== 16'hFFFF || fatal_cnt !== 16'd21845) begin
            $display("FAIL cnt_sat got %h/%0d exp ffff/21845", corr_cnt, fatal_cnt); errors++;
        end
        c_beat(ERR_IN);
        tick();
        checks++;
        if (corr_cnt !== 16'hFFFF || fatal_cnt !== 16'd21846) begin
            $display("FAIL cnt_sat_hold got %h/%0d exp ffff/21846", corr_cnt, fatal_cnt); errors++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_generate();
        test_check();
        test_back_to_back();
        test_stall();
        test_reset_midstream();
`ifdef ECC_HDR_ERR_CNT_EN
        test_counters();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
